// File: rtl/frame_painter_pkg.sv
// Shared state encoding, framebuffer geometry and palette indices for the frame painter.
package frame_painter_pkg;

   localparam int FB_W_DEF = 320;
   localparam int FB_H_DEF = 240;

   // Palette indices as decoded by the VGA driver's colour lookup.
   localparam logic [3:0] PAL_BLACK  = 4'd0;
   localparam logic [3:0] PAL_RED    = 4'd4;
   localparam logic [3:0] PAL_WATER  = 4'd5;
   localparam logic [3:0] PAL_LOG    = 4'd6;
   localparam logic [3:0] BG_GRASS   = 4'd8;
   localparam logic [3:0] PAL_ROAD   = 4'd12;
   localparam logic [3:0] PAL_PLAYER = 4'd13;
   localparam logic [3:0] PAL_WHITE  = 4'd15;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      WAIT_CMD,
      DRAW,
      DONE
   } state_t;

   function automatic logic rect_empty(input logic [9:0] w, input logic [9:0] h);
      return (w == 10'd0) || (h == 10'd0);
   endfunction

endpackage

// File: rtl/frame_painter_rect_scanner.sv
// Walks a rectangle one position per step, x fastest, and flags the final position.
module rect_scanner
   import frame_painter_pkg::*;
#(
   parameter int LIM_W = FB_W_DEF,
   parameter int LIM_H = FB_H_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       step,
   input  logic [9:0] org_x,
   input  logic [9:0] org_y,
   input  logic [9:0] size_w,
   input  logic [9:0] size_h,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y,
   output logic       last,
   output logic       nxt_inside
);

   // 11-bit positions so origin+size past 1023 stays off-screen instead of wrapping.
   logic [10:0] px_q, px_d;
   logic [10:0] py_q, py_d;
   logic [10:0] org_x_q, org_x_d;
   logic [10:0] end_x_q, end_x_d;
   logic [10:0] end_y_q, end_y_d;

   always_comb begin
      // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
      px_d    = px_q;
      py_d    = py_q;
      org_x_d = org_x_q;
      end_x_d = end_x_q;
      end_y_d = end_y_q;
      if (load) begin
         px_d    = {1'b0, org_x};
         py_d    = {1'b0, org_y};
         org_x_d = {1'b0, org_x};
         end_x_d = {1'b0, org_x} + {1'b0, size_w} - 11'd1;
         end_y_d = {1'b0, org_y} + {1'b0, size_h} - 11'd1;
      end else if (step) begin
         if (px_q == end_x_q) begin
            px_d = org_x_q;
            py_d = py_q + 11'd1;
         end else begin
            px_d = px_q + 11'd1;
         end
      end
   end

   // NOTE: the scanner is a handful of flops, not a memory, so all of it takes the reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         px_q    <= '0;
         py_q    <= '0;
         org_x_q <= '0;
         end_x_q <= '0;
         end_y_q <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values of the others.
         px_q    <= px_d;
         py_q    <= py_d;
         org_x_q <= org_x_d;
         end_x_q <= end_x_d;
         end_y_q <= end_y_d;
      end
   end

   assign pos_x      = px_q[9:0];
   assign pos_y      = py_q[9:0];
   assign last       = (px_q == end_x_q) && (py_q == end_y_q);
   assign nxt_inside = (px_d < 11'(LIM_W)) && (py_d < 11'(LIM_H));

endmodule

// File: rtl/frame_painter.sv
// Per-frame background clear followed by rectangle rasterisation, one pixel per clock,
// feeding the double-buffered VGA driver's write port.
module frame_painter
   import frame_painter_pkg::*;
#(
   parameter int         FB_W      = FB_W_DEF,
   parameter int         FB_H      = FB_H_DEF,
   parameter logic [3:0] BG_COLOUR = BG_GRASS
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_update,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [9:0] cmd_x,
   input  logic [9:0] cmd_y,
   input  logic [9:0] cmd_w,
   input  logic [9:0] cmd_h,
   input  logic [3:0] cmd_colour,
   input  logic       cmd_last,
   output logic       valid,
   output logic [9:0] O_x,
   output logic [9:0] O_y,
   output logic [3:0] O_colour,
   output logic       frame_done,
   output logic       frame_overrun
);

   state_t     state_q, state_d;
   logic       fu_q, fu_d;
   logic       valid_q, valid_d;
   logic       cmd_ready_q, cmd_ready_d;
   logic [3:0] colour_q, colour_d;
   logic       frame_done_q, frame_done_d;
   logic       frame_overrun_q, frame_overrun_d;
   logic       last_q, last_d;

   logic       frame_edge;
   logic       handshake;
   logic       sc_load, sc_step, sc_last, sc_nxt_inside;
   logic [9:0] sc_org_x, sc_org_y, sc_w, sc_h;
   logic [9:0] sc_pos_x, sc_pos_y;

   assign frame_edge = frame_update & ~fu_q;
   assign handshake  = cmd_valid & cmd_ready_q;

   rect_scanner #(
      .LIM_W (FB_W),
      .LIM_H (FB_H)
   ) u_scanner (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (sc_load),
      .step       (sc_step),
      .org_x      (sc_org_x),
      .org_y      (sc_org_y),
      .size_w     (sc_w),
      .size_h     (sc_h),
      .pos_x      (sc_pos_x),
      .pos_y      (sc_pos_y),
      .last       (sc_last),
      .nxt_inside (sc_nxt_inside)
   );

   always_comb begin
      state_d         = state_q;
      fu_d            = frame_update;
      valid_d         = valid_q;
      cmd_ready_d     = cmd_ready_q;
      colour_d        = colour_q;
      frame_done_d    = frame_done_q;
      frame_overrun_d = 1'b0;
      last_d          = last_q;
      sc_load         = 1'b0;
      sc_step         = 1'b0;
      sc_org_x        = 10'd0;
      sc_org_y        = 10'd0;
      sc_w            = 10'(FB_W);
      sc_h            = 10'(FB_H);

      // A frame edge restarts the clear from any state, abandoning whatever was in flight.
      if (frame_edge) begin
         state_d         = CLEAR;
         sc_load         = 1'b1;
         valid_d         = sc_nxt_inside;
         colour_d        = BG_COLOUR;
         cmd_ready_d     = 1'b0;
         frame_done_d    = 1'b0;
         frame_overrun_d = (state_q == CLEAR) || (state_q == WAIT_CMD) || (state_q == DRAW);
      end else begin
         case (state_q)
            IDLE: begin
               valid_d     = 1'b0;
               cmd_ready_d = 1'b0;
            end
            CLEAR: begin
               if (sc_last) begin
                  state_d     = WAIT_CMD;
                  valid_d     = 1'b0;
                  cmd_ready_d = 1'b1;
               end else begin
                  sc_step = 1'b1;
                  valid_d = sc_nxt_inside;
               end
            end
            WAIT_CMD: begin
               valid_d     = 1'b0;
               cmd_ready_d = 1'b1;
               if (handshake) begin
                  last_d   = cmd_last;
                  colour_d = cmd_colour;
                  if (rect_empty(cmd_w, cmd_h)) begin
                     if (cmd_last) begin
                        state_d      = DONE;
                        cmd_ready_d  = 1'b0;
                        frame_done_d = 1'b1;
                     end
                  end else begin
                     state_d     = DRAW;
                     cmd_ready_d = 1'b0;
                     sc_load     = 1'b1;
                     sc_org_x    = cmd_x;
                     sc_org_y    = cmd_y;
                     sc_w        = cmd_w;
                     sc_h        = cmd_h;
                     valid_d     = sc_nxt_inside;
                  end
               end
            end
            DRAW: begin
               if (sc_last) begin
                  valid_d = 1'b0;
                  if (last_q) begin
                     state_d      = DONE;
                     frame_done_d = 1'b1;
                  end else begin
                     state_d     = WAIT_CMD;
                     cmd_ready_d = 1'b1;
                  end
               end else begin
                  sc_step = 1'b1;
                  valid_d = sc_nxt_inside;
               end
            end
            DONE: begin
               valid_d      = 1'b0;
               cmd_ready_d  = 1'b0;
               frame_done_d = 1'b1;
            end
            default: begin
               state_d     = IDLE;
               valid_d     = 1'b0;
               cmd_ready_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         fu_q            <= 1'b0;
         valid_q         <= 1'b0;
         cmd_ready_q     <= 1'b0;
         colour_q        <= 4'd0;
         frame_done_q    <= 1'b0;
         frame_overrun_q <= 1'b0;
         last_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         fu_q            <= fu_d;
         valid_q         <= valid_d;
         cmd_ready_q     <= cmd_ready_d;
         colour_q        <= colour_d;
         frame_done_q    <= frame_done_d;
         frame_overrun_q <= frame_overrun_d;
         last_q          <= last_d;
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign valid         = valid_q;
   assign O_x           = sc_pos_x;
   assign O_y           = sc_pos_y;
   assign O_colour      = colour_q;
   assign frame_done    = frame_done_q;
   assign frame_overrun = frame_overrun_q;

endmodule

// File: tb/tb_frame_painter.sv
// Directed bench: full-size painter for clear/draw/clip/abort, small-frame painter for mid-DRAW abort.
module tb_frame_painter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic       m_fu, m_cmd_valid, m_cmd_last, m_cmd_ready, m_valid, m_frame_done, m_frame_overrun;
   logic [9:0] m_cmd_x, m_cmd_y, m_cmd_w, m_cmd_h, m_x, m_y;
   logic [3:0] m_cmd_colour, m_colour;

   logic       s_fu, s_cmd_valid, s_cmd_last, s_cmd_ready, s_valid, s_frame_done, s_frame_overrun;
   logic [9:0] s_cmd_x, s_cmd_y, s_cmd_w, s_cmd_h, s_x, s_y;
   logic [3:0] s_cmd_colour, s_colour;

   frame_painter u_main (
      .clk           (clk),
      .rst_n         (rst_n),
      .frame_update  (m_fu),
      .cmd_valid     (m_cmd_valid),
      .cmd_ready     (m_cmd_ready),
      .cmd_x         (m_cmd_x),
      .cmd_y         (m_cmd_y),
      .cmd_w         (m_cmd_w),
      .cmd_h         (m_cmd_h),
      .cmd_colour    (m_cmd_colour),
      .cmd_last      (m_cmd_last),
      .valid         (m_valid),
      .O_x           (m_x),
      .O_y           (m_y),
      .O_colour      (m_colour),
      .frame_done    (m_frame_done),
      .frame_overrun (m_frame_overrun)
   );

   frame_painter #(
      .FB_W (16),
      .FB_H (8)
   ) u_small (
      .clk           (clk),
      .rst_n         (rst_n),
      .frame_update  (s_fu),
      .cmd_valid     (s_cmd_valid),
      .cmd_ready     (s_cmd_ready),
      .cmd_x         (s_cmd_x),
      .cmd_y         (s_cmd_y),
      .cmd_w         (s_cmd_w),
      .cmd_h         (s_cmd_h),
      .cmd_colour    (s_cmd_colour),
      .cmd_last      (s_cmd_last),
      .valid         (s_valid),
      .O_x           (s_x),
      .O_y           (s_y),
      .O_colour      (s_colour),
      .frame_done    (s_frame_done),
      .frame_overrun (s_frame_overrun)
   );

   typedef struct {
      logic [9:0] x, y, w, h;
      logic [3:0] colour;
      logic       last;
      int         n_scan;
      int         n_pix;
      int         lx, ly;
   } vec_t;

   localparam int NV = 7;
   vec_t vec [NV];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int err, cyc, npix, order_err, col_err, seq_err, bound_err, lx, ly, ex, ey;

      vec[0] = '{10'd318, 10'd239, 10'd4,  10'd2, 4'd4,  1'b0, 8,  2,  319, 239};
      vec[1] = '{10'd5,   10'd5,   10'd0,  10'd3, 4'd1,  1'b0, 0,  0,  -1,  -1};
      vec[2] = '{10'd0,   10'd0,   10'd1,  10'd1, 4'd7,  1'b0, 1,  1,  0,   0};
      vec[3] = '{10'd1000,10'd3,   10'd30, 10'd1, 4'd2,  1'b0, 30, 0,  -1,  -1};
      vec[4] = '{10'd300, 10'd100, 10'd30, 10'd2, 4'd12, 1'b0, 60, 40, 319, 101};
      vec[5] = '{10'd0,   10'd238, 10'd2,  10'd3, 4'd5,  1'b0, 6,  4,  1,   239};
      vec[6] = '{10'd10,  10'd20,  10'd3,  10'd2, 4'd13, 1'b1, 6,  6,  12,  21};

      m_fu = 0; m_cmd_valid = 0; m_cmd_last = 0; m_cmd_x = 0; m_cmd_y = 0;
      m_cmd_w = 0; m_cmd_h = 0; m_cmd_colour = 0;
      s_fu = 0; s_cmd_valid = 0; s_cmd_last = 0; s_cmd_x = 0; s_cmd_y = 0;
      s_cmd_w = 0; s_cmd_h = 0; s_cmd_colour = 0;
      rst_n = 0;
      tick();
      tick();
      check("reset_valid", m_valid, 0);
      check("reset_x", m_x, 0);
      check("reset_y", m_y, 0);
      check("reset_colour", m_colour, 0);
      check("reset_ready", m_cmd_ready, 0);
      check("reset_done", m_frame_done, 0);
      check("reset_overrun", m_frame_overrun, 0);
      rst_n = 1;

      // Idle with frame_update low: nothing moves.
      err = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (m_valid !== 1'b0 || m_cmd_ready !== 1'b0 || m_frame_done !== 1'b0) err++;
      end
      check("idle_quiet", err, 0);

      // Small frame (16x8): clear, start a draw, abort it mid-way.
      s_fu = 1;
      tick();
      check("s_first_valid", s_valid, 1);
      check("s_first_xy", {s_y, s_x}, 0);
      check("s_no_overrun_from_idle", s_frame_overrun, 0);
      cyc = 0;
      while (s_cmd_ready !== 1'b1 && cyc < 300) begin
         tick();
         cyc++;
      end
      check("s_clear_len", cyc, 128);
      s_fu = 0;
      s_cmd_x = 10'd2; s_cmd_y = 10'd2; s_cmd_w = 10'd10; s_cmd_h = 10'd4;
      s_cmd_colour = 4'd5; s_cmd_last = 0; s_cmd_valid = 1;
      tick();
      s_cmd_valid = 0;
      check("s_draw_first", {s_valid, s_y, s_x}, {1'b1, 10'd2, 10'd2});
      repeat (5) tick();
      check("s_draw_mid", {s_valid, s_y, s_x, s_colour}, {1'b1, 10'd2, 10'd7, 4'd5});
      s_fu = 1;
      tick();
      check("s_overrun_pulse", s_frame_overrun, 1);
      check("s_restart", {s_valid, s_y, s_x, s_colour}, {1'b1, 10'd0, 10'd0, 4'd8});
      check("s_restart_ready_done", {s_cmd_ready, s_frame_done}, 0);
      tick();
      check("s_overrun_one_cycle", s_frame_overrun, 0);
      check("s_restart_step", s_x, 1);
      s_fu = 0;

      // Full-size clear, frame_update held high for 3200 cycles.
      m_fu = 1;
      tick();
      check("clr_first", {m_valid, m_y, m_x, m_colour}, {1'b1, 10'd0, 10'd0, 4'd8});
      check("clr_no_overrun_from_idle", m_frame_overrun, 0);
      ex = 0; ey = 0; npix = 0; order_err = 0; col_err = 0; lx = -1; ly = -1; cyc = 0;
      while (m_valid === 1'b1 && cyc < 80000) begin
         npix++;
         if (m_x !== 10'(ex) || m_y !== 10'(ey)) order_err++;
         if (m_colour !== 4'd8) col_err++;
         lx = int'(m_x);
         ly = int'(m_y);
         ex++;
         if (ex == 320) begin
            ex = 0;
            ey++;
         end
         tick();
         cyc++;
         if (cyc == 3200) m_fu = 0;
      end
      check("clr_count", npix, 76800);
      check("clr_order_errors", order_err, 0);
      check("clr_colour_errors", col_err, 0);
      check("clr_last_x", lx, 319);
      check("clr_last_y", ly, 239);
      check("clr_then_ready", m_cmd_ready, 1);
      err = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (m_valid !== 1'b0 || m_cmd_ready !== 1'b1) err++;
      end
      check("clr_no_restart", err, 0);

      // Rectangle commands, compared position by position against the scan model.
      for (int v = 0; v < NV; v++) begin
         cyc = 0;
         while (m_cmd_ready !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
         end
         check($sformatf("v%0d_ready_before", v), m_cmd_ready, 1);
         m_cmd_x = vec[v].x; m_cmd_y = vec[v].y; m_cmd_w = vec[v].w; m_cmd_h = vec[v].h;
         m_cmd_colour = vec[v].colour; m_cmd_last = vec[v].last; m_cmd_valid = 1;
         tick();
         m_cmd_valid = 0;
         m_cmd_x = 10'($urandom); m_cmd_y = 10'($urandom); m_cmd_w = 10'($urandom);
         m_cmd_h = 10'($urandom); m_cmd_colour = 4'($urandom); m_cmd_last = 1'($urandom);
         seq_err = 0; bound_err = 0; npix = 0; lx = -1; ly = -1;
         for (int k = 0; k <= vec[v].n_scan + 1; k++) begin
            logic ev;
            ev = 1'b0;
            ex = 0;
            ey = 0;
            if (k < vec[v].n_scan) begin
               ex = int'(vec[v].x) + k % int'(vec[v].w);
               ey = int'(vec[v].y) + k / int'(vec[v].w);
               ev = (ex < 320) && (ey < 240);
            end
            if (m_valid !== ev) seq_err++;
            else if (ev && (m_x !== 10'(ex) || m_y !== 10'(ey) || m_colour !== vec[v].colour))
               seq_err++;
            if (m_valid === 1'b1) begin
               npix++;
               lx = int'(m_x);
               ly = int'(m_y);
               if (m_x >= 10'd320 || m_y >= 10'd240) bound_err++;
            end
            if (k == vec[v].n_scan) begin
               check($sformatf("v%0d_ready_after", v), m_cmd_ready, !vec[v].last);
               check($sformatf("v%0d_frame_done", v), m_frame_done, vec[v].last);
            end
            tick();
         end
         check($sformatf("v%0d_sequence", v), seq_err, 0);
         check($sformatf("v%0d_bounds", v), bound_err, 0);
         check($sformatf("v%0d_pixels", v), npix, vec[v].n_pix);
         check($sformatf("v%0d_last_x", v), lx, vec[v].lx);
         check($sformatf("v%0d_last_y", v), ly, vec[v].ly);
      end

      // DONE ignores offered commands until the next frame edge.
      m_cmd_valid = 1;
      err = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (m_frame_done !== 1'b1 || m_cmd_ready !== 1'b0 || m_valid !== 1'b0) err++;
      end
      check("done_hold", err, 0);
      m_cmd_valid = 0;

      // New frame from DONE: no overrun; then abort the clear with another edge.
      m_fu = 1;
      tick();
      check("done_edge_restart", {m_valid, m_y, m_x, m_colour}, {1'b1, 10'd0, 10'd0, 4'd8});
      check("done_edge_no_overrun", m_frame_overrun, 0);
      check("done_edge_clears_done", m_frame_done, 0);
      repeat (49) tick();
      check("clr2_progress", {m_y, m_x}, {10'd0, 10'd49});
      m_fu = 0;
      tick();
      m_fu = 1;
      tick();
      check("clr_abort_overrun", m_frame_overrun, 1);
      check("clr_abort_restart", {m_valid, m_y, m_x}, {1'b1, 10'd0, 10'd0});
      tick();
      check("clr_abort_pulse_width", m_frame_overrun, 0);

      // Asynchronous reset mid-clear.
      #2;
      rst_n = 0;
      #1;
      check("rst_mid_outputs", {m_valid, m_y, m_x, m_colour, m_cmd_ready}, 0);
      m_fu = 0;
      tick();
      rst_n = 1;
      err = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (m_valid !== 1'b0 || m_cmd_ready !== 1'b0 || m_frame_done !== 1'b0) err++;
      end
      check("rst_mid_idle", err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
